rgb_hex_rx: RTL and testbench
=============================

RGB_HEX_RX -- requirements
Module: rgb_hex_rx

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 50_000_000: maximum idle gap between characters of one frame, in clk cycles.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 rxdata  input  8  received UART byte; valid only while rxvalid=1.
REQ-005 rxvalid  input  1  one-cycle strobe, one received byte per strobe; never stalled.
REQ-006 r  output  8  red value of last complete frame.
REQ-007 g  output  8  green value of last complete frame.
REQ-008 b  output  8  blue value of last complete frame.
REQ-009 done  output  1  one-cycle pulse: r/g/b just updated.
REQ-010 err  output  1  one-cycle pulse: partial frame aborted (bad char or timeout).
REQ-011 busy  output  1  high while a partial frame is held (1..5 digits collected).

Function
REQ-012 Frame: six ASCII hex digits, order R-high, R-low, G-high, G-low, B-high, B-low; mirror of the transmit-side encoding.
REQ-013 Accepted digits: 0x30-0x39 -> 0-9; 0x41-0x46 and 0x61-0x66 -> 10-15.
REQ-014 Outputs registered; done/err/busy/r/g/b change only on clk edges.
REQ-015 FSM states: IDLE (count=0), COLLECT (count=1..5); 3-bit digit count, 24-bit shift register.
REQ-016 IDLE, rxvalid with digit -> shift nibble in, count=1, COLLECT.
REQ-017 IDLE, rxvalid with 0x0D/0x0A -> ignored, stay IDLE, no pulse.
REQ-018 IDLE, rxvalid with any other byte -> err=1 next cycle, stay IDLE.
REQ-019 COLLECT, rxvalid with digit, count<5 -> shift, count+1.
REQ-020 COLLECT, rxvalid with digit, count=5 -> r/g/b loaded from the 24 assembled bits and done=1 on the same edge, count=0, IDLE; latency one cycle from the 6th strobe.
REQ-021 COLLECT, rxvalid with 0x0D/0x0A -> discard partial, count=0, IDLE, err=1.
REQ-022 COLLECT, rxvalid with non-hex byte -> discard partial, count=0, IDLE, err=1.
REQ-023 Timeout counter clears on every rxvalid and in IDLE; increments each COLLECT cycle without rxvalid.
REQ-024 Counter reaching TIMEOUT_CYCLES-1 in COLLECT -> discard partial, IDLE, err=1.
REQ-025 rxvalid on the same edge as timeout expiry: byte wins, timeout ignored.
REQ-026 r/g/b hold value across err, timeouts and partial frames; only REQ-020 modifies them.
REQ-027 done and err never asserted in the same cycle; busy=1 iff state=COLLECT.
REQ-028 Back-to-back frames with rxvalid on consecutive cycles accepted without loss.

Reset
REQ-029 rst_n low: state=IDLE, count=0, shift register=0, timeout counter=0, r=g=b=0x00, done=err=busy=0, immediately, independent of clk.
REQ-030 Reset mid-frame discards the partial frame; first strobe after release is treated as digit 1.

Structure
REQ-031 Package rgb_uart_pkg holds state enum, ASCII constants (CR, LF, digit ranges) and default TIMEOUT_CYCLES.
REQ-032 One combinational sub-module hex_decode: 8-bit ASCII in, 4-bit nibble plus is_hex flag out.

Verification
REQ-033 Strobes "1","A","2","b","3","C" -> one cycle after 6th strobe: r=0x1A, g=0x2B, b=0x3C, done=1 for one cycle, busy=0.
REQ-034 Strobes "F","F","G" -> err=1 one cycle after "G", busy=0, r/g/b unchanged; then "000000" -> r=g=b=0x00, done=1.
REQ-035 TIMEOUT_CYCLES=16: "1","2" then 20 silent cycles -> err=1 exactly once, busy=0; "123456" afterwards -> r=0x12, g=0x34, b=0x56.
REQ-036 "12" then 0x0D -> err=1; lone 0x0A in IDLE -> no done/err pulse.
REQ-037 Two frames "ABCDEF","012345" on consecutive-cycle strobes -> two done pulses, final r=0x01, g=0x23, b=0x45.
REQ-038 rst_n low after three digits, released -> all outputs 0; "FFFFFF" -> r=g=b=0xFF, done=1.

Source files
------------

// File: rtl/rgb_uart_pkg.sv
// Shared types and constants for the RGB hex-frame UART receiver.
// Receive-side mirror of the transmit-side encoding.
package rgb_uart_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_LF  = 8'h0A;
    localparam logic [7:0] ASCII_0   = 8'h30;
    localparam logic [7:0] ASCII_9   = 8'h39;
    localparam logic [7:0] ASCII_UCA = 8'h41;
    localparam logic [7:0] ASCII_UCF = 8'h46;
    localparam logic [7:0] ASCII_LCA = 8'h61;
    localparam logic [7:0] ASCII_LCF = 8'h66;

    localparam int FRAME_DIGITS           = 6;
    localparam int DEFAULT_TIMEOUT_CYCLES = 50_000_000;

endpackage

// File: rtl/hex_decode.sv
// ASCII hex digit to nibble decoder, purely combinational.
// Accepts 0-9, A-F and a-f; anything else clears is_hex.
module hex_decode
    import rgb_uart_pkg::*;
(
    input  logic [7:0] ch,
    output logic [3:0] nib,
    output logic       is_hex
);

    logic dig;
    logic up;
    logic lo;

    assign dig = (ch >= ASCII_0)   && (ch <= ASCII_9);
    assign up  = (ch >= ASCII_UCA) && (ch <= ASCII_UCF);
    assign lo  = (ch >= ASCII_LCA) && (ch <= ASCII_LCF);

    // Letters: low nibble of 'A'/'a' is 1, so +9 maps them onto 10..15
    always_comb begin
        nib    = 4'd0;
        is_hex = 1'b0;
        unique case (1'b1)
            dig: begin
                nib    = ch[3:0];
                is_hex = 1'b1;
            end
            up, lo: begin
                nib    = ch[3:0] + 4'd9;
                is_hex = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/rgb_hex_rx.sv
// Collects six ASCII hex digits into an RGB triple.
// Aborts a partial frame on a bad character or an idle timeout.
module rgb_hex_rx
    import rgb_uart_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rxdata,
    input  logic       rxvalid,
    output logic [7:0] r,
    output logic [7:0] g,
    output logic [7:0] b,
    output logic       done,
    output logic       err,
    output logic       busy
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]    LAST = 3'(FRAME_DIGITS - 1);

    state_t        state;
    state_t        state_n;
    logic [2:0]    count;
    logic [23:0]   shreg;
    logic [23:0]   asm_w;
    logic [TW-1:0] tcnt;
    logic [3:0]    nib;
    logic          is_hex;
    logic          is_eol;
    logic          shift;
    logic          timeout;
    logic          done_d;
    logic          err_d;

    hex_decode u_dec (
        .ch     (rxdata),
        .nib    (nib),
        .is_hex (is_hex)
    );

    assign is_eol  = (rxdata == ASCII_CR) || (rxdata == ASCII_LF);
    assign shift   = rxvalid && is_hex;
    assign asm_w   = {shreg[19:0], nib};
    assign timeout = (state == COLLECT) && !rxvalid && (tcnt == TMAX);
    assign busy    = (state == COLLECT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (shift) state_n = COLLECT;
            end
            COLLECT: begin
                if (rxvalid) begin
                    if (!is_hex || count == LAST) state_n = IDLE;
                end else if (timeout) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // A received byte always takes priority over a same-cycle timeout
    always_comb begin
        done_d = 1'b0;
        err_d  = 1'b0;
        unique case (state)
            IDLE: begin
                err_d = rxvalid && !is_hex && !is_eol;
            end
            COLLECT: begin
                done_d = shift && (count == LAST);
                err_d  = (rxvalid && !is_hex) || timeout;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 3'd0;
            shreg <= 24'd0;
            tcnt  <= '0;
            r     <= 8'd0;
            g     <= 8'd0;
            b     <= 8'd0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            done <= done_d;
            err  <= err_d;
            if (done_d) begin
                r <= asm_w[23:16];
                g <= asm_w[15:8];
                b <= asm_w[7:0];
            end
            if (state_n == IDLE) begin
                count <= 3'd0;
                shreg <= 24'd0;
            end else if (shift) begin
                count <= count + 3'd1;
                shreg <= asm_w;
            end
            if (rxvalid || state == IDLE || timeout) begin
                tcnt <= '0;
            end else begin
                tcnt <= tcnt + TW'(1);
            end
        end
    end

endmodule

// File: tb/tb_rgb_hex_rx.sv
// Self-checking bench for rgb_hex_rx: directed frames plus
// randomized byte streams against a queue-based frame model.
module tb_rgb_hex_rx;

    localparam int T = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rxdata;
    logic       rxvalid;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       done;
    logic       err;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int n_done = 0;
    int n_err  = 0;

    int         q[$];
    int         gap;
    logic [7:0] mr, mg, mb;
    logic       md, me;

    rgb_hex_rx #(.TIMEOUT_CYCLES(T)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rxdata  (rxdata),
        .rxvalid (rxvalid),
        .r       (r),
        .g       (g),
        .b       (b),
        .done    (done),
        .err     (err),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int hexval(input logic [7:0] c);
        if (c >= 8'd48 && c <= 8'd57)  return int'(c) - 48;
        if (c >= 8'd65 && c <= 8'd70)  return int'(c) - 55;
        if (c >= 8'd97 && c <= 8'd102) return int'(c) - 87;
        return -1;
    endfunction

    task automatic model_reset();
        q.delete();
        gap = 0;
        mr = 8'h00; mg = 8'h00; mb = 8'h00;
        md = 1'b0;  me = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic [7:0] d);
        int h;
        md = 1'b0;
        me = 1'b0;
        if (v) begin
            gap = 0;
            h = hexval(d);
            if (h >= 0) begin
                q.push_back(h);
                if (q.size() == 6) begin
                    mr = 8'(q[0] * 16 + q[1]);
                    mg = 8'(q[2] * 16 + q[3]);
                    mb = 8'(q[4] * 16 + q[5]);
                    md = 1'b1;
                    q.delete();
                end
            end else if (q.size() == 0) begin
                me = (d != 8'h0D) && (d != 8'h0A);
            end else begin
                me = 1'b1;
                q.delete();
            end
        end else if (q.size() > 0) begin
            gap++;
            if (gap == T) begin
                me = 1'b1;
                q.delete();
                gap = 0;
            end
        end
    endtask

    task automatic compare_all();
        check("r", {24'd0, r}, {24'd0, mr});
        check("g", {24'd0, g}, {24'd0, mg});
        check("b", {24'd0, b}, {24'd0, mb});
        check("done", {31'd0, done}, {31'd0, md});
        check("err", {31'd0, err}, {31'd0, me});
        check("busy", {31'd0, busy}, {31'd0, q.size() > 0});
        check("excl", {31'd0, done & err}, 32'd0);
    endtask

    task automatic cyc(input logic v, input logic [7:0] d);
        @(negedge clk);
        rxvalid = v;
        rxdata  = d;
        model_step(v, d);
        @(posedge clk);
        #1;
        if (done) n_done++;
        if (err)  n_err++;
        compare_all();
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 8'($urandom));
    endtask

    task automatic send_str(input string s, input int sp);
        for (int i = 0; i < s.len(); i++) begin
            cyc(1'b1, s[i]);
            if (i != s.len() - 1) idle(sp);
        end
    endtask

    task automatic do_reset();
        rxvalid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    string hexchars = "0123456789ABCDEFabcdef";

    initial begin
        int k, e0, d0;
        logic [7:0] c;
        rst_n   = 1'b0;
        rxvalid = 1'b0;
        rxdata  = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;

        send_str("1A2b3C", 1);
        check("f1_r", {24'd0, r}, 32'h1A);
        check("f1_g", {24'd0, g}, 32'h2B);
        check("f1_b", {24'd0, b}, 32'h3C);
        check("f1_done", {31'd0, done}, 32'd1);
        check("f1_busy", {31'd0, busy}, 32'd0);
        idle(1);
        check("f1_pulse", {31'd0, done}, 32'd0);

        send_str("FFG", 0);
        check("bad_err", {31'd0, err}, 32'd1);
        check("bad_busy", {31'd0, busy}, 32'd0);
        check("bad_hold", {8'd0, r, g, b}, 32'h1A2B3C);
        idle(2);
        send_str("000000", 0);
        check("zero_rgb", {8'd0, r, g, b}, 32'h000000);
        check("zero_done", {31'd0, done}, 32'd1);

        send_str("12", 0);
        e0 = n_err;
        idle(20);
        check("to_once", n_err - e0, 32'd1);
        check("to_busy", {31'd0, busy}, 32'd0);
        send_str("123456", 0);
        check("to_rgb", {8'd0, r, g, b}, 32'h123456);

        send_str("12", 0);
        cyc(1'b1, 8'h0D);
        check("cr_err", {31'd0, err}, 32'd1);
        cyc(1'b1, 8'h0A);
        check("lf_done", {31'd0, done}, 32'd0);
        check("lf_err", {31'd0, err}, 32'd0);

        d0 = n_done;
        send_str("ABCDEF012345", 0);
        check("b2b_cnt", n_done - d0, 32'd2);
        check("b2b_rgb", {8'd0, r, g, b}, 32'h012345);

        send_str("abc", 0);
        do_reset();
        check("rst_rgb", {8'd0, r, g, b}, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        send_str("FFFFFF", 0);
        check("rst_ff", {8'd0, r, g, b}, 32'hFFFFFF);
        check("rst_done", {31'd0, done}, 32'd1);

        for (int it = 0; it < 2500; it++) begin
            k = $urandom_range(0, 99);
            if (k < 75) begin
                c = 8'(hexchars[$urandom_range(0, 21)]);
                cyc(1'b1, c);
                idle($urandom_range(0, 2));
            end else if (k < 82) begin
                cyc(1'b1, ($urandom_range(0, 1) == 0) ? 8'h0D : 8'h0A);
            end else if (k < 90) begin
                cyc(1'b1, 8'($urandom));
            end else if (k < 99) begin
                idle($urandom_range(12, 20));
            end else begin
                do_reset();
            end
        end
        idle(T + 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
